// File: rtl/prog_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit program memory words; holds the core in reset until loaded.
// Optional trailing modulo-256 checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

    state_t          state, state_d;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [15:0]     len_full;
    logic [ADDR_W:0] cnt;
    logic [1:0]      byte_idx;
    logic [23:0]     word;
    logic            accept;
    logic            ready_d;
    logic            len_too_long;
    logic            last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign accept       = s_valid & s_ready;
    assign len_full     = {s_data, len_lo};
    assign len_too_long = 32'(len_full) > (32'd1 << ADDR_W);
    assign last_word    = (32'(cnt) + 32'd1) == 32'(len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   state_d = LEN_LO;
            LEN_LO: if (accept) state_d = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else if (len_too_long) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA:   if (accept && byte_idx == 2'd3) state_d = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            DONE:   if (reload) state_d = LEN_LO;
            ERR:    if (reload) state_d = LEN_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:   if (accept) state_d = (s_data == csum) ? DONE : ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state_d == CSUM) ready_d = 1'b1;
`endif
    end

    // Outputs are registered from the next state so they change in step with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            cnt        <= '0;
            byte_idx   <= '0;
            word       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            s_ready    <= ready_d;
            mem_we     <= (state_d == WRITE);
            done       <= (state_d == DONE);
            core_rst_n <= (state_d == DONE);
            error      <= (state_d == ERR);

            if (state == LEN_LO && accept) begin
                len_lo <= s_data;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (state == LEN_LO) begin
                csum <= '0;
            end
`endif
            if (state == LEN_HI && accept) begin
                len      <= len_full;
                cnt      <= '0;
                byte_idx <= '0;
            end
            if (state == DATA && accept) begin
                word     <= {s_data, word[23:8]};
                byte_idx <= byte_idx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= csum + s_data;
`endif
                if (byte_idx == 2'd3) begin
                    mem_addr  <= cnt[ADDR_W-1:0];
                    mem_wdata <= {s_data, word};
                end
            end
            if (state == WRITE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (ADDR_W=10 and ADDR_W=2) fed random streams, writes checked by monitors.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0]  a_data;  logic a_valid, a_ready, a_reload, a_we, a_crn, a_done, a_err;
    logic [9:0]  a_addr;  logic [31:0] a_wdata;
    logic [7:0]  b_data;  logic b_valid, b_ready, b_reload, b_we, b_crn, b_done, b_err;
    logic [1:0]  b_addr;  logic [31:0] b_wdata;

    prog_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .reload(a_reload), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .core_rst_n(a_crn), .done(a_done), .error(a_err));

    prog_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .reload(b_reload), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .core_rst_n(b_crn), .done(b_done), .error(b_err));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_a[$];
    wr_t exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                check("a_mem_addr", 32'(a_addr), e.addr);
                check("a_mem_wdata", a_wdata, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b_we === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                check("b_mem_addr", 32'(b_addr), e.addr);
                check("b_mem_wdata", b_wdata, e.data);
            end
        end
    end

    function automatic logic [3:0] status(input int d);
        return (d == 0) ? {a_ready, a_done, a_err, a_crn} : {b_ready, b_done, b_err, b_crn};
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? a_ready : b_ready;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin a_valid = v; a_data = b; end
        else        begin b_valid = v; b_data = b; end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        set_in(d, 1'b1, b);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready_of(d) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        set_in(d, 1'b0, b);
    endtask

    task automatic gap(input bit gaps);
        int g;
        g = gaps ? int'($urandom_range(0, 3)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a legal image produces one write per word at ascending addresses; an oversize
    // length aborts right after the header; a bad checksum aborts after all words are written.
    task automatic run_load(input int d, input int unsigned len, input logic [31:0] w[$],
                            input bit gaps, input bit bad_csum);
        int unsigned depth;
        bit          legal, ok_end;
        logic [7:0]  sum;
        logic [31:0] word;
        logic [15:0] len16;
        bit          finished;
        wr_t         e;
        depth = (d == 0) ? 1024 : 4;
        legal = (len <= depth);
        sum   = 8'd0;
        len16 = 16'(len);
        if (legal) begin
            for (int i = 0; i < int'(len); i++) begin
                e.addr = i;
                e.data = w[i];
                if (d == 0) exp_a.push_back(e); else exp_b.push_back(e);
                sum = sum + w[i][7:0] + w[i][15:8] + w[i][23:16] + w[i][31:24];
            end
        end
        send_byte(d, len16[7:0]);
        gap(gaps);
        send_byte(d, len16[15:8]);
        if (legal) begin
            for (int i = 0; i < int'(len); i++) begin
                word = w[i];
                for (int k = 0; k < 4; k++) begin
                    gap(gaps);
                    send_byte(d, word[8*k +: 8]);
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            gap(gaps);
            send_byte(d, bad_csum ? sum + 8'd1 : sum);
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ok_end = legal && !bad_csum;
`else
        ok_end = legal;
`endif
        if (len == 0) begin
            @(posedge clk);
            @(negedge clk);
            check("len0_done_two_cycles", 32'(status(d) >> 2 & 4'b0001), 32'd1);
        end
        finished = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (status(d)[2] === 1'b1 || status(d)[1] === 1'b1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("load_finish_timeout", 32'd0, 32'd1);
        @(negedge clk);
        // {s_ready, done, error, core_rst_n}
        check(ok_end ? "status_done" : "status_error", 32'(status(d)),
              ok_end ? 32'b0101 : 32'b0010);
        check("writes_outstanding", (d == 0) ? exp_a.size() : exp_b.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload(input int d);
        if (d == 0) a_reload = 1'b1; else b_reload = 1'b1;
        @(posedge clk);
        #1;
        if (d == 0) a_reload = 1'b0; else b_reload = 1'b0;
        check("reload_status", 32'(status(d)), 32'b1000);
    endtask

    task automatic check_reset_a();
        check("rst_s_ready", 32'(a_ready), 32'd0);
        check("rst_mem_we", 32'(a_we), 32'd0);
        check("rst_mem_addr", 32'(a_addr), 32'd0);
        check("rst_mem_wdata", a_wdata, 32'd0);
        check("rst_core_rst_n", 32'(a_crn), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_error", 32'(a_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w[$];
        int unsigned len;
        wr_t e;
        a_data = '0; a_valid = 1'b0; a_reload = 1'b0;
        b_data = '0; b_valid = 1'b0; b_reload = 1'b0;
        rst = 1'b1;
        #22;
        check_reset_a();
        check("rst_b_status", 32'(status(1)), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        w.delete(); w.push_back(32'h0000_0013);
        run_load(0, 1, w, 1'b0, 1'b0);

        do_reload(0);
        w.delete(); w.push_back(32'h0050_0093); w.push_back(32'h0010_0113); w.push_back(32'h0000_006F);
        run_load(0, 3, w, 1'b1, 1'b0);

        do_reload(0);
        w.delete();
        run_load(0, 0, w, 1'b0, 1'b0);

        repeat (4) begin
            do_reload(0);
            len = $urandom_range(1, 12);
            w.delete();
            for (int i = 0; i < int'(len); i++) w.push_back($urandom);
            run_load(0, len, w, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset after half of word 1: word 0 lands, the partial word must not.
        do_reload(0);
        w.delete(); w.push_back($urandom); w.push_back($urandom);
        e.addr = 0; e.data = w[0];
        exp_a.push_back(e);
        send_byte(0, 8'd2);
        send_byte(0, 8'd0);
        for (int k = 0; k < 4; k++) send_byte(0, w[0][8*k +: 8]);
        for (int k = 0; k < 2; k++) send_byte(0, w[1][8*k +: 8]);
        rst = 1'b1;
        #1;
        check_reset_a();
        check("rst_mid_writes_outstanding", exp_a.size(), 32'd0);
        #5;
        rst = 1'b0;
        w.delete(); w.push_back($urandom); w.push_back($urandom);
        run_load(0, 2, w, 1'b1, 1'b0);
        do_reload(0);

        w.delete();
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        run_load(1, 4, w, 1'b1, 1'b0);
        do_reload(1);
        run_load(1, 5, w, 1'b0, 1'b0);
        do_reload(1);
        len = $urandom_range(1, 4);
        run_load(1, len, w, 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        w.delete(); w.push_back(32'h0102_0304);
        run_load(0, 1, w, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the RV32i core's program memory. It receives a length-prefixed little-endian byte stream over a valid/ready handshake and assembles bytes into 32-bit instruction words. Each word is written into program memory at consecutive word addresses. The core is held in reset until the image is fully and correctly loaded, which replaces file-based preloading of program memory.

## Interface
- `ADDR_W`, 10, program memory word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a byte when `s_valid & s_ready` at a rising edge.
- `reload`  in  1  single-cycle request to start a new load; honoured only in DONE or ERR.
- `mem_we`  out  1  program memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  instruction word.
- `core_rst_n`  out  1  core reset, active-low; 0 until the load succeeds.
- `done`  out  1  load completed successfully.
- `error`  out  1  load aborted.

## Operation
- Stream format: `LEN[7:0]`, `LEN[15:8]`, then LEN×4 data bytes. Each word is sent LSB first: byte0 → `[7:0]` … byte3 → `[31:24]`.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR (plus CSUM, see Configuration).
- IDLE: entered on reset; moves to LEN_LO unconditionally on the next clock.
- LEN_LO / LEN_HI: capture one byte each.
  - After LEN_HI, LEN = 0 → DONE.
  - LEN > 2^ADDR_W → ERR.
  - Otherwise → DATA with word counter = 0 and byte index = 0.
- DATA: shift accepted bytes into the word register. On the 4th byte → WRITE.
- WRITE: one cycle with `mem_we`=1, `mem_addr`=word counter, `mem_wdata`=assembled word. Then the word counter increments.
  - Counter = LEN → DONE.
  - Otherwise → DATA.
- DONE: `done`=1, `core_rst_n`=1. Further stream bytes are not accepted.
- ERR: `error`=1, `core_rst_n`=0. Further stream bytes are not accepted.
- `reload`=1 in DONE or ERR:
  - next cycle `done`=0, `error`=0, `core_rst_n`=0;
  - state → LEN_LO;
  - memory contents are not cleared.
- `reload` in any other state is ignored.
- Width rules:
  - Word counter is ADDR_W+1 bits, so LEN = 2^ADDR_W is legal and fills memory exactly.
  - `mem_addr` = counter[ADDR_W-1:0].

## Timing
- Reset values: `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst_n`=0, `done`=0, `error`=0, state = IDLE.
- All outputs are registered.
- `s_ready`=1 exactly in LEN_LO, LEN_HI, DATA and CSUM; 0 in IDLE, WRITE, DONE and ERR.
- Byte throughput: 1 per cycle while `s_valid` is held. Each word costs 4 accept cycles + 1 WRITE cycle.
- The 4th byte is accepted at edge t. `mem_we` is high in the cycle after edge t, for exactly one cycle.
- Last write strobe at cycle c → `done` and `core_rst_n` rise at cycle c+1.
- `s_valid` gaps stall the FSM with no state or data change. The partial word is held.
- Reset mid-operation (any state):
  - all outputs return to reset values asynchronously;
  - any partial word is discarded;
  - the next load restarts from LEN_LO via IDLE.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the final word, or directly after the header when LEN = 0, enter CSUM and accept one more byte.
  - The expected value is the 8-bit modulo-256 sum of all data bytes; header bytes are excluded.
  - Match → DONE the next cycle.
  - Mismatch → ERR.
  - The running sum resets to 0 in LEN_LO.
- Undefined: no CSUM state, and no checksum byte is expected or consumed.

## Test plan
- ADDR_W=10, stream `01 00 13 00 00 00` (with macro: trailing `13`):
  - one `mem_we` pulse, `mem_addr`=0, `mem_wdata`=0x00000013;
  - then `done`=1, `core_rst_n`=1, `s_ready`=0.
- LEN=3 with random 0–3 cycle `s_valid` gaps, words 0x00500093, 0x00100113, 0x0000006F:
  - writes at addresses 0, 1, 2 in order with exact data;
  - no extra `mem_we` pulses.
- LEN=0 (`00 00`, with macro plus `00`):
  - no `mem_we`;
  - `done`=1 two cycles after the last accepted byte.
- ADDR_W=2, LEN=4: fills addresses 0–3 and reaches `done`=1.
- ADDR_W=2, LEN=5: `error`=1, `core_rst_n` stays 0, no `mem_we`, `s_ready`=0.
- Reset and reload:
  - assert `rst` after 2 of 4 bytes of word 1 in a LEN=2 load → all outputs at reset values;
  - a subsequent full load writes correct data;
  - then pulse `reload` in DONE → `done`=0, `core_rst_n`=0, `s_ready`=1 next cycle.
- With macro, LEN=1 word 0x01020304 and checksum byte `0B`: `error`=1; the word is still written at address 0.
